// File: rtl/vchip8_framebuffer_ctrl.sv
// vchip8_framebuffer_ctrl: executes toggle-strobed CHIP-8 video commands on a 64x32x1
// framebuffer (set / xor / clear / flag ack) with one pending slot, plus a registered
// scan-out read port.
module vchip8_framebuffer_ctrl #(
    parameter int unsigned FB_W = 64,
    parameter int unsigned FB_H = 32,
    localparam int unsigned DEPTH = FB_W * FB_H,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [15:0]   i_cmd_word,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_pixel,
    output logic          o_busy,
    output logic          o_collision,
    output logic          o_overrun
);
    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_XOR   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_ACK   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RMW_WR = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_mem [DEPTH];
    logic            r_tog_q;
    logic            r_pend_valid;
    logic [1:0]      r_pend_op;
    logic            r_pend_p;
    logic [AW-1:0]   r_pend_addr;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_rmw_addr;
    logic            r_rmw_p;
    logic            r_rmw_old;
    logic            r_collision;
    logic            r_overrun;
    logic            r_busy;
    logic            r_rd_pixel;

    logic            w_new;
    logic            w_consume;
    logic            w_drop;
    logic            w_accept;
    logic            w_pend_valid_nxt;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic            w_mem_wdata;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_coll_set;
    logic            w_flags_clr;
    logic            w_rmw_load;
    logic            w_collision_nxt;
    logic            w_overrun_nxt;
    logic            w_busy_nxt;
    logic            w_unused_rsvd;

    // Bit 12 of the command word is reserved and carries no meaning here.
    assign w_unused_rsvd = i_cmd_word[12];

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, memory command port, pending-slot bookkeeping and flag updates.
    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_pend_addr;
        w_mem_wdata = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_coll_set  = 1'b0;
        w_flags_clr = 1'b0;
        w_rmw_load  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
                    w_consume = 1'b1;
                    case (r_pend_op)
                        OP_SET: begin
                            w_mem_we    = 1'b1;
                            w_mem_wdata = r_pend_p;
                        end
                        OP_XOR: begin
                            w_rmw_load  = 1'b1;
                            w_state_nxt = S_RMW_WR;
                        end
                        OP_CLEAR: begin
                            w_mem_we    = 1'b1;
                            w_mem_addr  = '0;
                            w_cnt_nxt   = AW'(1);
                            w_state_nxt = S_CLEAR;
                        end
                        OP_ACK: begin
                            w_flags_clr = 1'b1;
                        end
                    endcase
                end
            end
            S_RMW_WR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_rmw_addr;
                w_mem_wdata = r_rmw_old ^ r_rmw_p;
                w_coll_set  = r_rmw_old & r_rmw_p;
                w_state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_cnt_nxt  = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A slot being consumed this edge can take a new command; otherwise a full slot drops it.
        w_new            = i_cmd_word[15] ^ r_tog_q;
        w_drop           = w_new & r_pend_valid & ~w_consume;
        w_accept         = w_new & ~w_drop;
        w_pend_valid_nxt = w_accept | (r_pend_valid & ~w_consume);
        w_collision_nxt  = (r_collision & ~w_flags_clr) | w_coll_set;
        w_overrun_nxt    = (r_overrun & ~w_flags_clr) | w_drop;
        w_busy_nxt       = w_pend_valid_nxt | (w_state_nxt != S_IDLE);
    end

    // Toggle tracking, pending slot, XOR operand capture, clear counter and status flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tog_q      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_op    <= 2'b00;
            r_pend_p     <= 1'b0;
            r_pend_addr  <= '0;
            r_cnt        <= '0;
            r_rmw_addr   <= '0;
            r_rmw_p      <= 1'b0;
            r_rmw_old    <= 1'b0;
            r_collision  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tog_q      <= i_cmd_word[15];
            r_pend_valid <= w_pend_valid_nxt;
            if (w_accept) begin
                r_pend_op   <= i_cmd_word[14:13];
                r_pend_p    <= i_cmd_word[11];
                r_pend_addr <= i_cmd_word[AW-1:0];
            end
            r_cnt <= w_cnt_nxt;
            if (w_rmw_load) begin
                r_rmw_addr <= r_pend_addr;
                r_rmw_p    <= r_pend_p;
                r_rmw_old  <= r_mem[r_pend_addr];
            end
            r_collision <= w_collision_nxt;
            r_overrun   <= w_overrun_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Framebuffer write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Scan-out read port: one-cycle latency, returns pre-write data on a same-edge collision.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_pixel <= 1'b0;
        end else begin
            r_rd_pixel <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_pixel  = r_rd_pixel;
    assign o_busy      = r_busy;
    assign o_collision = r_collision;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_vchip8_framebuffer_ctrl.sv
// tb_vchip8_framebuffer_ctrl: scoreboard bench with a timeline reference model of the
// command executor (acceptance/drop by start times, functional pixel updates).
module tb_vchip8_framebuffer_ctrl;
    localparam int DEPTH = 2048;
    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_ACK = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cmd_word;
    logic [10:0] rd_addr;
    logic        rd_pixel;
    logic        busy;
    logic        collision;
    logic        overrun;

    always #5 clk = ~clk;

    vchip8_framebuffer_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_word  (cmd_word),
        .i_rd_addr   (rd_addr),
        .o_rd_pixel  (rd_pixel),
        .o_busy      (busy),
        .o_collision (collision),
        .o_overrun   (overrun)
    );

    typedef enum int {K_PIX, K_BUSY, K_COLL, K_OVR} kind_t;
    typedef struct {
        kind_t kind;
        int    due;
        logic  exp;
        int    addr;
    } chk_t;

    chk_t sb[$];
    int   edges = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) edges <= edges + 1;

    // Reference model: pixel image plus a timeline of when each accepted command starts.
    bit   fb[DEPTH];
    bit   fb_save[DEPTH];
    logic tog;
    int   m_last_start;
    int   m_free;
    int   m_coll_edge;
    int   m_ack_edge;
    int   m_drop_edge;

    function automatic void expect_at(kind_t k, logic e, int due, int addr = -1);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.due  = due;
        c.addr = addr;
        sb.push_back(c);
    endfunction

    function automatic void model_reset();
        m_last_start = 0;
        m_free       = 0;
        m_coll_edge  = -1;
        m_ack_edge   = -1;
        m_drop_edge  = -1;
        tog          = 1'b0;
    endfunction

    // Monitor: compare every expectation on the falling edge after the edge it refers to.
    always @(negedge clk) begin
        logic act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= edges) begin
                case (sb[i].kind)
                    K_PIX:   act = rd_pixel;
                    K_BUSY:  act = busy;
                    K_COLL:  act = collision;
                    default: act = overrun;
                endcase
                n_cmp++;
                if (sb[i].due < edges) begin
                    n_bad++;
                    $display("FAIL %s stale check due=%0d seen at edge=%0d", sb[i].kind.name(), sb[i].due, edges);
                end else if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s addr=%0d edge=%0d actual=%b required=%b",
                             sb[i].kind.name(), sb[i].addr, edges, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one command (toggling the strobe) and predict its fate.
    task automatic send(input logic [1:0] op, input logic p, input logic [10:0] a, input logic rsvd = 1'b0);
        int t;
        int s;
        t        = edges + 1;
        tog      = ~tog;
        cmd_word = {tog, op, rsvd, p, a};
        expect_at(K_BUSY, 1'b1, t);
        if (m_last_start > t) begin
            m_drop_edge = t;
            expect_at(K_OVR, 1'b1, t);
        end else begin
            s            = (t + 1 > m_free) ? t + 1 : m_free;
            m_last_start = s;
            case (op)
                OP_SET: begin
                    fb[a]  = p;
                    m_free = s + 1;
                end
                OP_XOR: begin
                    if (fb[a] && p) m_coll_edge = s + 1;
                    fb[a]  = fb[a] ^ p;
                    m_free = s + 2;
                end
                OP_CLR: begin
                    for (int i = 0; i < DEPTH; i++) fb[i] = 1'b0;
                    m_free = s + DEPTH;
                end
                default: begin
                    m_ack_edge = s;
                    m_free     = s + 1;
                end
            endcase
        end
        step();
    endtask

    // Wait for the executor to go idle, checking busy fall timing and both flags.
    task automatic drain();
        if (m_free - 2 >= edges) expect_at(K_BUSY, 1'b1, m_free - 2);
        if (m_free - 1 >= edges) expect_at(K_BUSY, 1'b0, m_free - 1);
        while (edges < m_free - 1) step();
        expect_at(K_COLL, (m_coll_edge > m_ack_edge) ? 1'b1 : 1'b0, edges);
        expect_at(K_OVR, (m_drop_edge > m_ack_edge) ? 1'b1 : 1'b0, edges);
        step();
    endtask

    task automatic read_chk(input int a);
        rd_addr = 11'(a);
        expect_at(K_PIX, fb[a], edges + 1, a);
        step();
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) read_chk(a);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog edges=%0d required=finish", edges);
        $fatal(1, "timeout");
    end

    initial begin
        int         addrs[8];
        int         r;
        logic [1:0] op;

        reset    = 1'b1;
        cmd_word = 16'h0000;
        rd_addr  = 11'h000;
        model_reset();
        step(2);
        expect_at(K_BUSY, 1'b0, edges);
        expect_at(K_COLL, 1'b0, edges);
        expect_at(K_OVR,  1'b0, edges);
        expect_at(K_PIX,  1'b0, edges);
        step();
        reset = 1'b0;
        step();

        // SET x=5 y=3 p=1 (0x88C5), then XOR it off (0x28C5), then ACK (0xE000).
        send(OP_SET, 1'b1, {5'd3, 6'd5});
        drain();
        read_chk(11'h0C5);
        send(OP_XOR, 1'b1, {5'd3, 6'd5});
        drain();
        read_chk(11'h0C5);
        send(OP_ACK, 1'b0, 11'h000);
        drain();

        // Light corners and middle back-to-back, with an XOR collision in the stream.
        send(OP_SET, 1'b1, 11'd0);
        send(OP_SET, 1'b1, 11'd1000);
        send(OP_SET, 1'b1, 11'd2047);
        send(OP_XOR, 1'b1, 11'd2047);
        send(OP_SET, 1'b1, 11'd2047);
        drain();
        read_chk(0);
        read_chk(1000);
        read_chk(2047);

        // CLEAR with three consecutive toggles arriving mid-clear.
        send(OP_CLR, 1'b0, 11'd0);
        step(10);
        send(OP_SET, 1'b1, 11'd5);
        send(OP_SET, 1'b1, 11'd6);
        send(OP_SET, 1'b1, 11'd7);
        drain();
        read_chk(0);
        read_chk(1000);
        read_chk(2047);
        read_chk(5);
        read_chk(6);
        read_chk(7);

        // Acknowledge, then a sustained SET stream of one toggle per cycle.
        send(OP_ACK, 1'b0, 11'd0);
        drain();
        for (int i = 0; i < 8; i++) addrs[i] = $urandom_range(8, DEPTH - 1);
        for (int i = 0; i < 8; i++) send(OP_SET, 1'b1, 11'(addrs[i]));
        drain();
        for (int i = 0; i < 8; i++) read_chk(addrs[i]);

        // Randomised command mix with random gaps and random reserved bit.
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 99);
            op = (r < 45) ? OP_SET : (r < 90) ? OP_XOR : (r < 98) ? OP_ACK : OP_CLR;
            send(op, 1'($urandom), 11'($urandom), 1'($urandom));
            step($urandom_range(0, 3));
        end
        drain();
        sweep();

        // Reset in the middle of a CLEAR, with collision set beforehand.
        send(OP_SET, 1'b1, 11'd600);
        send(OP_XOR, 1'b1, 11'd600);
        send(OP_SET, 1'b1, 11'd600);
        send(OP_SET, 1'b1, 11'd1500);
        send(OP_SET, 1'b1, 11'd100);
        drain();
        fb_save = fb;
        send(OP_CLR, 1'b0, 11'd0);
        while (edges < m_last_start + 499) step();
        reset    = 1'b1;
        cmd_word = 16'h0000;
        expect_at(K_BUSY, 1'b0, edges);
        expect_at(K_COLL, 1'b0, edges);
        expect_at(K_OVR,  1'b0, edges);
        expect_at(K_PIX,  1'b0, edges);
        fb = fb_save;
        for (int i = 0; i < 500; i++) fb[i] = 1'b0;
        model_reset();
        step(2);
        reset = 1'b0;
        step();
        send(OP_SET, 1'b1, 11'd50);
        drain();
        sweep();

        step(2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
